// File: rtl/ysyx_25040111_axi_sram.sv
// ysyx_25040111_axi_sram: single-outstanding AXI4 slave SRAM with INCR/FIXED bursts,
// byte strobes, per-beat decode errors and a programmable first-beat read latency.
module ysyx_25040111_axi_sram #(
    parameter int          DEPTH  = 65536,
    parameter logic [31:0] BASE   = 32'h8000_0000,
    parameter int          RD_LAT = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awid,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    output logic [3:0]  bid,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic [3:0]  rid
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, RWAIT, RDATA, WDATA, WRESP} state_t;

    state_t        r_state, w_next;
    logic          r_live;
    logic          r_fixed;
    logic [31:0]   r_addr;
    logic [3:0]    r_id;
    logic [8:0]    r_cnt;
    logic [7:0]    r_lat;
    logic [1:0]    r_bresp;
    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   w_off;
    logic          w_inr;
    logic          w_last;
    logic [1:0]    w_wresp;
    logic [AW-1:0] w_idx;
    logic          w_unused;

    assign w_off    = r_addr - BASE;
    assign w_inr    = w_off < 32'(4 * DEPTH);
    assign w_idx    = w_off[AW+1:2];
    assign w_last   = r_cnt == 9'd1;
    assign w_wresp  = !w_inr ? 2'b11 : (wlast != w_last) ? 2'b10 : 2'b00;
    assign w_unused = ^{awsize, arsize};

    assign rlast = r_state == RDATA && w_last;
    assign rdata = (r_state == RDATA && w_inr) ? r_mem[w_idx] : 32'h0;
    assign rresp = (r_state == RDATA && !w_inr) ? 2'b11 : 2'b00;
    assign rid   = r_state == RDATA ? r_id : 4'h0;
    assign bresp = r_state == WRESP ? r_bresp : 2'b00;
    assign bid   = r_state == WRESP ? r_id : 4'h0;

    // r_live keeps every ready low for the cycle right after reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
        end
    end

    always_comb begin
        w_next  = r_state;
        arready = 1'b0;
        awready = 1'b0;
        rvalid  = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (r_state)
            IDLE: begin
                arready = r_live;
                awready = r_live && !arvalid;
                if (arvalid && r_live)
                    w_next = (RD_LAT > 0) ? RWAIT : RDATA;
                else if (awvalid && r_live)
                    w_next = WDATA;
            end
            RWAIT: w_next = r_lat == 8'd0 ? RDATA : RWAIT;
            RDATA: begin
                rvalid = 1'b1;
                w_next = (rready && w_last) ? IDLE : RDATA;
            end
            WDATA: begin
                wready = 1'b1;
                w_next = (wvalid && w_last) ? WRESP : WDATA;
            end
            WRESP: begin
                bvalid = 1'b1;
                w_next = bready ? IDLE : WRESP;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_bresp <= 2'b00;
        end else if (arvalid && arready) begin
            r_addr  <= araddr;
            r_id    <= arid;
            r_cnt   <= {1'b0, arlen} + 9'd1;
            r_fixed <= arburst == 2'b00;
            r_lat   <= 8'(RD_LAT - 1);
        end else if (awvalid && awready) begin
            r_addr  <= awaddr;
            r_id    <= awid;
            r_cnt   <= {1'b0, awlen} + 9'd1;
            r_fixed <= awburst == 2'b00;
            r_bresp <= 2'b00;
        end else if (rvalid && rready) begin
            r_addr <= r_fixed ? r_addr : r_addr + 32'd4;
            r_cnt  <= r_cnt - 9'd1;
        end else if (wvalid && wready) begin
            r_addr  <= r_fixed ? r_addr : r_addr + 32'd4;
            r_cnt   <= r_cnt - 9'd1;
            r_bresp <= w_wresp > r_bresp ? w_wresp : r_bresp;
        end else if (r_state == RWAIT) begin
            r_lat <= r_lat - 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && wvalid && wready && w_inr)
            for (int i = 0; i < 4; i++)
                if (wstrb[i])
                    r_mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
    end
endmodule

// File: tb/tb_ysyx_25040111_axi_sram.sv
// tb_ysyx_25040111_axi_sram: directed AXI4 transactions against the SRAM slave with
// hand-computed expectations for data, responses, latency and handshake ordering.
module tb_ysyx_25040111_axi_sram;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        awvalid = 1'b0, awready;
    logic [31:0] awaddr = '0;
    logic [3:0]  awid = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = 3'd2;
    logic [1:0]  awburst = 2'b01;
    logic        wvalid = 1'b0, wready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        bvalid, bready = 1'b0;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        arvalid = 1'b0, arready;
    logic [31:0] araddr = '0;
    logic [3:0]  arid = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = 3'd2;
    logic [1:0]  arburst = 2'b01;
    logic        rvalid, rready = 1'b0;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    ysyx_25040111_axi_sram dut (
        .clock(clock), .reset(reset),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rid(rid)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] rd_data [16];
    logic        rd_last [16];
    logic [1:0]  rd_resp [16];
    logic [3:0]  rd_id [16];
    int          rd_lat;
    int          rd_gaps;
    logic        chk_aw_blocked = 1'b0;
    logic [1:0]  wr_resp;
    logic [3:0]  wr_bid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                             input logic [31:0] d0, input logic [31:0] dstep,
                             input logic [3:0] strb, input int last_at);
        int n;
        awaddr = addr; awid = id; awlen = len; awburst = 2'b01; awvalid = 1'b1;
        #1;
        n = 0;
        while (!awready && n < 50) begin tick(); n++; end
        if (n == 50) chk("aw_timeout", 0, 1);
        tick();
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wvalid = 1'b1; wdata = d0 + b * dstep; wstrb = strb; wlast = (b + 1 == last_at);
            #1;
            n = 0;
            while (!wready && n < 50) begin tick(); n++; end
            if (n == 50) begin chk("w_timeout", 0, 1); break; end
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        #1;
        chk("bvalid_after_beats", bvalid, 1);
        n = 0;
        while (!bvalid && n < 50) begin tick(); n++; end
        wr_resp = bresp; wr_bid = bid;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input bit toggle, input int abort_at);
        int n;
        araddr = addr; arid = id; arlen = len; arburst = 2'b01; arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 50) begin tick(); n++; end
        if (n == 50) chk("ar_timeout", 0, 1);
        if (chk_aw_blocked) chk("aw_blocked_same_cycle", awready, 0);
        tick();
        arvalid = 1'b0; rready = !toggle;
        rd_gaps = 0; rd_lat = 0;
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            while (!rvalid && n < 50) begin
                if (chk_aw_blocked) chk("aw_blocked_rwait", awready, 0);
                tick(); n++;
            end
            if (n == 50) begin chk("r_timeout", 0, 1); break; end
            if (b == 0) rd_lat = 1 + n; else rd_gaps += n;
            if (chk_aw_blocked) chk("aw_blocked_rdata", awready, 0);
            rd_data[b] = rdata; rd_last[b] = rlast; rd_resp[b] = rresp; rd_id[b] = rid;
            if (b + 1 == abort_at) begin
                reset = 1'b0;
                tick();
                chk("abort_rvalid", rvalid, 0);
                chk("abort_arready", arready, 0);
                tick();
                chk("abort_hold_rvalid", rvalid, 0);
                reset = 1'b1; rready = 1'b0;
                tick();
                chk("release_arready", arready, 1);
                return;
            end
            if (toggle) begin
                tick();
                chk("stall_rvalid", rvalid, 1);
                chk("stall_rdata", rdata, rd_data[b]);
                chk("stall_rlast", rlast, rd_last[b]);
                rready = 1'b1;
                tick();
                rready = 1'b0;
            end else begin
                tick();
            end
        end
        rready = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_arready", arready, 0);
        chk("rst_awready", awready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ids", {rid, bid}, 0);
        chk("rst_resps", {rresp, bresp}, 0);
        reset = 1'b1;
        tick();
        chk("idle_arready", arready, 1);
        chk("idle_awready", awready, 1);

        axi_write(32'h8000_0010, 4'd5, 8'd0, 32'hDEAD_BEEF, 32'h0, 4'hF, 1);
        chk("single_bresp", wr_resp, 0);
        chk("single_bid", wr_bid, 5);
        axi_read(32'h8000_0010, 4'd3, 8'd0, 1'b0, 0);
        chk("single_lat", rd_lat, 3);
        chk("single_rdata", rd_data[0], 32'hDEAD_BEEF);
        chk("single_rid", rd_id[0], 3);
        chk("single_rlast", rd_last[0], 1);
        chk("single_rresp", rd_resp[0], 0);

        axi_write(32'h8000_0000, 4'hA, 8'd7, 32'hC0DE_0000, 32'h11, 4'hF, 8);
        chk("burst_bresp", wr_resp, 0);
        chk("burst_bid", wr_bid, 4'hA);
        axi_read(32'h8000_0000, 4'd1, 8'd7, 1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("burst_rdata%0d", i), rd_data[i], 32'hC0DE_0000 + 32'h11 * i);
            chk($sformatf("burst_rlast%0d", i), rd_last[i], i == 7);
        end
        chk("burst_gaps", rd_gaps, 0);
        axi_read(32'h8000_0000, 4'd1, 8'd7, 1'b1, 0);
        for (int i = 0; i < 8; i++)
            chk($sformatf("toggle_rdata%0d", i), rd_data[i], 32'hC0DE_0000 + 32'h11 * i);
        chk("toggle_rlast", rd_last[7], 1);

        axi_write(32'h8000_0100, 4'd1, 8'd0, 32'hAAAA_AAAA, 32'h0, 4'hF, 1);
        axi_write(32'h8000_0100, 4'd1, 8'd0, 32'h1122_3344, 32'h0, 4'b0101, 1);
        axi_read(32'h8000_0100, 4'd1, 8'd0, 1'b0, 0);
        chk("strobe_rdata", rd_data[0], 32'hAA22_AA44);

        awaddr = 32'h8000_0200; awid = 4'd6; awlen = 8'd0; awvalid = 1'b1;
        chk_aw_blocked = 1'b1;
        axi_read(32'h8000_0000, 4'd2, 8'd1, 1'b0, 0);
        chk_aw_blocked = 1'b0;
        #1;
        chk("aw_after_rlast", awready, 1);
        chk("race_rdata0", rd_data[0], 32'hC0DE_0000);
        chk("race_rdata1", rd_data[1], 32'hC0DE_0011);
        axi_write(32'h8000_0200, 4'd6, 8'd0, 32'h5555_6666, 32'h0, 4'hF, 1);
        chk("race_bid", wr_bid, 6);
        axi_read(32'h8000_0200, 4'd2, 8'd0, 1'b0, 0);
        chk("race_wdata", rd_data[0], 32'h5555_6666);

        axi_read(32'h7FFF_FFFC, 4'd4, 8'd0, 1'b0, 0);
        chk("oor_rresp", rd_resp[0], 2'b11);
        chk("oor_rdata", rd_data[0], 0);
        axi_write(32'h8000_0300, 4'd7, 8'd3, 32'h1, 32'h1, 4'hF, 2);
        chk("early_wlast_bresp", wr_resp, 2'b10);
        axi_write(32'h8003_FFFC, 4'd8, 8'd1, 32'h7777_8888, 32'h1, 4'hF, 2);
        chk("top_bresp", wr_resp, 2'b11);
        axi_read(32'h8003_FFFC, 4'd8, 8'd1, 1'b0, 0);
        chk("top_rdata0", rd_data[0], 32'h7777_8888);
        chk("top_rresp0", rd_resp[0], 2'b00);
        chk("top_rresp1", rd_resp[1], 2'b11);
        chk("top_rdata1", rd_data[1], 0);
        chk("top_rlast1", rd_last[1], 1);

        axi_read(32'h8000_0000, 4'd9, 8'd7, 1'b0, 3);
        chk("abort_beat3_data", rd_data[2], 32'hC0DE_0022);
        axi_read(32'h8000_0008, 4'd4, 8'd0, 1'b0, 0);
        chk("post_rst_rdata", rd_data[0], 32'hC0DE_0022);
        chk("post_rst_rid", rd_id[0], 4);
        axi_read(32'h8000_0010, 4'd4, 8'd0, 1'b0, 0);
        chk("post_rst_word4", rd_data[0], 32'hC0DE_0044);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ysyx_25040111_axi_sram.md
Name: ysyx_25040111_axi_sram

Overview:
AXI4 slave memory that sits directly downstream of the core's LSU master port and serves both instruction-cache refills and data loads/stores. It holds one outstanding transaction at a time and supports INCR bursts, which covers the icache line refills issued with arlen = tlen. A programmable read latency lets the bench exercise the core's handshake stalls. It is used as the memory model in the non-SoC build.

Parameters:
DEPTH, 65536, number of 32-bit words held.
BASE, 32'h8000_0000, byte address of word 0.
RD_LAT, 2, idle cycles between the AR handshake and the first R beat (0 allowed).

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
awvalid in 1, awready out 1, awaddr in 32, awid in 4, awlen in 8, awsize in 3, awburst in 2  write address channel
wvalid in 1, wready out 1, wdata in 32, wstrb in 4, wlast in 1  write data channel
bvalid out 1, bready in 1, bresp out 2, bid out 4  write response channel
arvalid in 1, arready out 1, araddr in 32, arid in 4, arlen in 8, arsize in 3, arburst in 2  read address channel
rvalid out 1, rready in 1, rdata out 32, rresp out 2, rlast out 1, rid out 4  read data channel

Behaviour:
- Reset is sampled on the clock edge while reset == 0.
  - During reset and on the first cycle after it, all valid and ready outputs are 0; rdata, rresp, bresp, rid and bid are 0; FSM = IDLE.
  - Memory contents are not cleared.
- Reset asserted mid-transaction aborts it immediately: the FSM returns to IDLE, no further beats are issued, and writes already committed stay committed.
- FSM states: IDLE, RWAIT, RDATA, WDATA, WRESP.
- IDLE:
  - arready = 1; awready = ~arvalid, so a read wins when AR and AW arrive in the same cycle.
  - On the AR handshake, latch the address, arid and beat count (arlen + 1). Go to RWAIT if RD_LAT > 0, else RDATA.
  - On the AW handshake, latch the address, awid and beat count (awlen + 1). Go to WDATA.
- RWAIT: count RD_LAT cycles, then go to RDATA. The first rvalid appears exactly RD_LAT + 1 cycles after the AR handshake edge.
- RDATA:
  - rvalid = 1; rdata, rresp, rid and rlast stay stable until rready.
  - Each accepted beat increments the word address by 4. arburst FIXED (2'b00) holds the address; WRAP is treated as INCR.
  - rlast = 1 only on beat arlen + 1.
  - After the last beat is accepted, go to IDLE; arready is high again on the next cycle.
  - With rready held 1, beats are back-to-back, one per cycle.
- WDATA:
  - wready = 1.
  - Each accepted beat writes the bytes selected by wstrb (bit i selects byte lane i) and advances the address as for reads.
  - The burst ends on the beat counter, not on wlast. Then go to WRESP.
- WRESP:
  - bvalid = 1 with bid = the latched awid, held until bready, then go to IDLE.
- Response codes:
  - OKAY (2'b00) normally.
  - SLVERR (2'b10) in bresp if wlast did not coincide with the final counted beat (early or missing).
  - DECERR (2'b11) for any beat whose address is outside [BASE, BASE + 4*DEPTH). Reads of such a beat return rdata = 0; writes are dropped. The bresp is the worst response seen in the burst.
- Word index = (addr − BASE) >> 2. addr[1:0] is ignored.
- awsize and arsize are ignored. Narrow accesses are expressed via wstrb; reads always return the full word.
- A burst that runs past the top of the range returns DECERR only for the out-of-range beats. There is no wrap to word 0.
- Throughput: one transaction at a time. At most one of rvalid and bvalid is high in any cycle.

Test Plan:
- RD_LAT=2: write 32'hDEADBEEF at 0x8000_0010 with wstrb=4'hF; then read with arid=3, arlen=0 → bresp=0, bid matches awid; rvalid rises 3 cycles after the AR handshake with rdata=DEADBEEF, rid=3, rlast=1.
- Burst read at 0x8000_0000, arlen=7, rready held 1 → 8 consecutive beats of words 0..7, rlast only on beat 8; rready toggled 1/0 → each beat's data held stable across the stall.
- Byte-strobe write of 32'h11223344 with wstrb=4'b0101 over a word holding 32'hAAAAAAAA → readback 32'hAA22AA44.
- arvalid and awvalid both high in the same IDLE cycle → AR accepted, awready=0 until the read's rlast beat completes, then AW accepted.
- Out-of-range read at 0x7FFF_FFFC → rresp=2'b11, rdata=0. Write burst awlen=3 with wlast asserted on beat 2 → bresp=2'b10 after exactly 4 beats.
- Assert reset during beat 3 of an 8-beat read → next cycle rvalid=0, arready=0. After release, IDLE with arready=1, and a new read returns correct data.
